// File: rtl/alu_wb_pkg.sv
// alu_wb_pkg: definitions shared by the execution stage and its multiplier.
//   - opcode constants (3-bit)
//   - FSM state encoding (2-bit)
//   - multiplier iteration count
//   - bit positions inside the optional {N,Z,C,V} flag vector
// The optional flag output is controlled by the ALU_WB_FLAGS_EN macro.
package alu_wb_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    MUL  = 2'b10,
    WB   = 2'b11
  } state_e;

  localparam int MUL_ITER = 16;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_wb_unit_mul.sv
// mul_shift_add: iterative shift-add multiplier, one partial product per step.
//   clk_i     system clock
//   rst_ni    synchronous active-low reset
//   load_i    capture operands, clear accumulator and counter
//   step_i    perform one iteration
//   mcand_i   multiplicand (WIDTH)
//   mplier_i  multiplier (WIDTH)
//   done_o    high during the step that completes the last iteration
//   prod_o    accumulator value after the current step (ACC_W bits)
// ACC_W is WIDTH for a truncated product, 2*WIDTH when the upper half is
// needed (ALU_WB_FLAGS_EN build, carry flag on MUL).
module mul_shift_add #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic             done_o,
  output logic [ACC_W-1:0] prod_o
);
  import alu_wb_pkg::*;

  logic [ACC_W-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       cnt_q;

  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // prod_o is the post-step value so the FSM can write back on the same
  // edge that retires the last iteration.
  assign prod_o = acc_d;
  assign done_o = step_i && (cnt_q == 4'(MUL_ITER - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (load_i) begin
      mcand_q  <= ACC_W'(mcand_i);
      mplier_q <= mplier_i;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step_i) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 4'd1;
    end
  end

endmodule

// File: rtl/alu_wb_unit.sv
// alu_wb_unit: execution stage behind the 8x16 register file.
// Captures R/S on start, runs one of eight operations and writes the result
// back through the register-file write port for exactly one cycle.
//   clk     system clock, rising edge
//   reset   synchronous active-low reset
//   start   operation request, sampled only in IDLE
//   op      opcode (ADD SUB AND OR XOR SHL SHR MUL)
//   dest    destination register index
//   R, S    operands from the register-file read ports
//   busy    high in EXEC, MUL and WB
//   done    one-cycle pulse, coincident with we
//   W       write-back data (holds after WB)
//   W_adr   write-back address (holds after WB)
//   flags   {N,Z,C,V}, only when ALU_WB_FLAGS_EN is defined
//   we      register-file write enable
//
// state | meaning
// IDLE  | waiting for start; operands captured on start
// EXEC  | single-cycle ALU result registered into W
// MUL   | 16 shift-add iterations, product registered into W on the last
// WB    | we/done high for one cycle
module alu_wb_unit #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    dest,
  input  logic [WIDTH-1:0] R,
  input  logic [WIDTH-1:0] S,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] W,
  output logic [AW-1:0]    W_adr,
`ifdef ALU_WB_FLAGS_EN
  output logic [3:0]       flags,
`endif
  output logic             we
);
  import alu_wb_pkg::*;

`ifdef ALU_WB_FLAGS_EN
  localparam int ACC_W = 2 * WIDTH;
`else
  localparam int ACC_W = WIDTH;
`endif

  state_e state_q, state_d;

  logic [2:0]       op_q;
  logic [AW-1:0]    dest_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] W_q;
  logic [AW-1:0]    W_adr_q;
  logic [WIDTH-1:0] alu_res;

  logic             accept;
  logic             mul_load;
  logic             mul_done;
  logic [ACC_W-1:0] mul_prod;

  assign accept   = (state_q == IDLE) && start;
  assign mul_load = accept && (op == OP_MUL);

  mul_shift_add #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_mul (
    .clk_i    (clk),
    .rst_ni   (reset),
    .load_i   (mul_load),
    .step_i   (state_q == MUL),
    .mcand_i  (R),
    .mplier_i (S),
    .done_o   (mul_done),
    .prod_o   (mul_prod)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = (op == OP_MUL) ? MUL : EXEC;
      EXEC: state_d = WB;
      MUL:  if (mul_done) state_d = WB;
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state_q != IDLE);
    we   = (state_q == WB);
    done = (state_q == WB);
  end

  // Single-cycle ALU on the frozen operands
  always_comb begin
    alu_res = '0;
    unique case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SHL:  alu_res = a_q << b_q[3:0];
      OP_SHR:  alu_res = a_q >> b_q[3:0];
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_WB_FLAGS_EN
  logic [3:0] alu_flags, mul_flags, flags_q;

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_N] = alu_res[WIDTH-1];
    alu_flags[FLAG_Z] = (alu_res == '0);
    unique case (op_q)
      OP_ADD: begin
        // The sum wrapped iff it came out smaller than an addend.
        alu_flags[FLAG_C] = (alu_res < a_q);
        alu_flags[FLAG_V] = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                            (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_flags[FLAG_C] = (a_q < b_q);
        alu_flags[FLAG_V] = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                            (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      default: begin
        alu_flags[FLAG_C] = 1'b0;
        alu_flags[FLAG_V] = 1'b0;
      end
    endcase
  end

  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_N] = mul_prod[WIDTH-1];
    mul_flags[FLAG_Z] = (mul_prod[WIDTH-1:0] == '0);
    mul_flags[FLAG_C] = |mul_prod[ACC_W-1:WIDTH];
    mul_flags[FLAG_V] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset)                          flags_q <= '0;
    else if (state_q == EXEC)            flags_q <= alu_flags;
    else if (state_q == MUL && mul_done) flags_q <= mul_flags;
  end

  assign flags = flags_q;
`endif

  // Operand capture and write-back registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q    <= '0;
      dest_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      W_q     <= '0;
      W_adr_q <= '0;
    end else begin
      if (accept) begin
        op_q   <= op;
        dest_q <= dest;
        a_q    <= R;
        b_q    <= S;
      end
      if (state_q == EXEC) begin
        W_q     <= alu_res;
        W_adr_q <= dest_q;
      end else if (state_q == MUL && mul_done) begin
        W_q     <= mul_prod[WIDTH-1:0];
        W_adr_q <= dest_q;
      end
    end
  end

  assign W     = W_q;
  assign W_adr = W_adr_q;

endmodule
